// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the MAC transmit/receive datapath.
// Holds the FCS-append state encoding, the CRC-32 constants, and the
// frame-timing defaults in dibits (one RMII clock carries two bits).
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        GAP
    } fcs_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after running a CRC over a frame plus its own FCS.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_MIN_DIBITS = 240;  // 60 bytes before FCS
    localparam int ETH_IFG_DIBITS = 48;   // 96 bit times

endpackage

// File: rtl/crc32_dibit.sv
// Combinational CRC-32 step over one RMII dibit (reflected polynomial).
// d[0] is shifted in before d[1], matching LSB-first byte order on the wire.
// Ports:
//   crc_in  [31:0]  current CRC register
//   d       [1:0]   dibit to absorb
//   crc_out [31:0]  CRC register after both bits
module crc32_dibit
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] w_c1;

    assign w_c1    = {1'b0, crc_in[31:1]} ^ ({32{crc_in[0] ^ d[0]}} & CRC32_POLY_REFL);
    assign crc_out = {1'b0, w_c1[31:1]}   ^ ({32{w_c1[0]   ^ d[1]}} & CRC32_POLY_REFL);

endmodule

// File: rtl/fcs_append.sv
// Transmit FCS stage: forwards a frame of RMII-order dibits with one cycle
// of latency, zero-pads short frames to the Ethernet minimum, appends the
// complemented CRC-32 and then holds off for the inter-frame gap.
// Ports:
//   clk           RMII reference clock, rising edge
//   rst           asynchronous reset, active low
//   axiiv/axiid   input dibit valid / data (one contiguous run per frame)
//   axiov/axiod   output dibit valid / data (TX_EN / TXD downstream)
//   data_end_out  pulse with the final FCS dibit
//   overrun       pulse for every valid input dibit that is dropped
module fcs_append
    import eth_pkg::*;
#(
    parameter int MIN_DIBITS = ETH_MIN_DIBITS,
    parameter int IFG_DIBITS = ETH_IFG_DIBITS,
    parameter bit PAD_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       data_end_out,
    output logic       overrun
);

    localparam int          GW    = (IFG_DIBITS < 1) ? 1 : $clog2(IFG_DIBITS + 1);
    localparam logic [7:0]  MIN_C = 8'(MIN_DIBITS);
    localparam logic [GW-1:0] IFG_C = GW'(IFG_DIBITS);

    fcs_state_t    r_state, w_state_n;
    logic [31:0]   r_crc, w_crc_n;
    logic [7:0]    r_cnt, w_cnt_n;
    logic [3:0]    r_idx, w_idx_n;
    logic [GW-1:0] r_gap, w_gap_n;
    logic          r_axiov, w_axiov_n;
    logic [1:0]    r_axiod, w_axiod_n;
    logic          r_end, w_end_n;

    logic [31:0]   w_crc_src;
    logic [1:0]    w_crc_d;
    logic [31:0]   w_crc_upd;
    logic [7:0]    w_cnt_inc;
    logic [1:0]    w_fcs_dibit;

    // A single CRC step serves both data and pad dibits. In IDLE the step
    // starts from the init value so the first dibit is absorbed immediately.
    assign w_crc_src = (r_state == IDLE) ? CRC32_INIT : r_crc;
    assign w_crc_d   = ((r_state == IDLE || r_state == DATA) && axiiv) ? axiid : 2'b00;

    crc32_dibit u_crc (
        .crc_in  (w_crc_src),
        .d       (w_crc_d),
        .crc_out (w_crc_upd)
    );

    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    // The CRC register already holds the last data/pad dibit by the time the
    // first FCS dibit is loaded, and stays frozen for the rest of the FCS.
    assign w_fcs_dibit = ~r_crc[{r_idx, 1'b0} +: 2];

    always_comb begin
        w_state_n = r_state;
        w_crc_n   = r_crc;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_gap_n   = r_gap;
        w_axiov_n = 1'b0;
        w_axiod_n = 2'b00;
        w_end_n   = 1'b0;
        case (r_state)
            IDLE: begin
                w_crc_n = CRC32_INIT;
                w_idx_n = 4'd0;
                if (axiiv) begin
                    w_state_n = DATA;
                    w_crc_n   = w_crc_upd;
                    w_cnt_n   = 8'd1;
                    w_axiov_n = 1'b1;
                    w_axiod_n = axiid;
                end
            end
            DATA: begin
                w_axiov_n = 1'b1;
                if (axiiv) begin
                    w_axiod_n = axiid;
                    w_crc_n   = w_crc_upd;
                    w_cnt_n   = w_cnt_inc;
                end else if (PAD_EN && (r_cnt < MIN_C)) begin
                    // First pad dibit goes out right behind the last data dibit.
                    w_state_n = PAD;
                    w_crc_n   = w_crc_upd;
                    w_cnt_n   = w_cnt_inc;
                end else begin
                    w_state_n = FCS;
                    w_axiod_n = w_fcs_dibit;
                    w_idx_n   = 4'd1;
                end
            end
            PAD: begin
                w_axiov_n = 1'b1;
                if (r_cnt >= MIN_C) begin
                    w_state_n = FCS;
                    w_axiod_n = w_fcs_dibit;
                    w_idx_n   = 4'd1;
                end else begin
                    w_crc_n = w_crc_upd;
                    w_cnt_n = w_cnt_inc;
                end
            end
            FCS: begin
                w_axiov_n = 1'b1;
                w_axiod_n = w_fcs_dibit;
                w_idx_n   = r_idx + 4'd1;
                if (r_idx == 4'd15) begin
                    w_end_n   = 1'b1;
                    w_state_n = GAP;
                    w_gap_n   = '0;
                end
            end
            GAP: begin
                // GAP spans the data_end cycle plus IFG_DIBITS more, so the
                // next frame is accepted IFG_DIBITS+1 cycles after data_end.
                if (r_gap == IFG_C) begin
                    w_state_n = IDLE;
                end else begin
                    w_gap_n = r_gap + GW'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_crc   <= CRC32_INIT;
            r_cnt   <= 8'd0;
            r_idx   <= 4'd0;
            r_gap   <= '0;
            r_axiov <= 1'b0;
            r_axiod <= 2'b00;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_crc   <= w_crc_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_gap   <= w_gap_n;
            r_axiov <= w_axiov_n;
            r_axiod <= w_axiod_n;
            r_end   <= w_end_n;
        end
    end

    assign axiov        = r_axiov;
    assign axiod        = r_axiod;
    assign data_end_out = r_end;
    // Flagged in the same cycle as the dropped dibit so it can never spill
    // into IDLE after the last GAP cycle.
    assign overrun      = axiiv && (r_state == PAD || r_state == FCS || r_state == GAP);

endmodule
